// File: rtl/prbs_checker_if.sv
// Serial link bundle between a PRBS bit source and the prbs_checker receiver.
// The bit source drives the master side; the checker takes the slave side.
interface prbs_checker_if;
    logic        EN;
    logic        DIN;
    logic        CLR;
    logic        LOCKED;
    logic        ERR;
    logic [15:0] ERR_COUNT;

    modport master (
        output EN,
        output DIN,
        output CLR,
        input  LOCKED,
        input  ERR,
        input  ERR_COUNT
    );

    modport slave (
        input  EN,
        input  DIN,
        input  CLR,
        output LOCKED,
        output ERR,
        output ERR_COUNT
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fills a local LFSR copy from the received bits,
// locks after a run of correct predictions, then flags and counts mismatched bits.
module prbs_checker #(
    parameter int                 WIDTH       = 7,
    parameter logic [WIDTH-1:0]   TAPS        = 7'b1100000,
    parameter int                 LOCK_THRESH = 16,
    parameter int                 LOSS_THRESH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    prbs_checker_if.slave bus
);

    localparam int         FILL_W   = $clog2(WIDTH + 1);
    localparam logic [7:0] LOCK_LIM = 8'(LOCK_THRESH - 1);
    localparam logic [7:0] LOSS_LIM = 8'(LOSS_THRESH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    sr;
    logic [FILL_W-1:0]   fill_cnt;
    logic [7:0]          match_cnt;
    logic [7:0]          miss_cnt;
    logic                locked_q;
    logic                err_q;
    logic [15:0]         err_cnt;

    logic                pred;
    logic                match;
    logic                fill_done;
    logic [WIDTH-1:0]    sr_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Prediction always comes from the register contents before this bit shifts in.
    assign pred      = ^(sr & TAPS);
    assign match     = (bus.DIN == pred);
    assign sr_next   = {sr[WIDTH-2:0], bus.DIN};
    assign fill_done = (fill_cnt == FILL_W'(WIDTH));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= HUNT;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.EN) begin
                sr <= sr_next;
                case (state)
                    HUNT: begin
                        if (!fill_done) begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end else if (match && (sr != '0)) begin
                            if (match_cnt == LOCK_LIM) begin
                                state     <= LOCK;
                                locked_q  <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        // An all-zero register cannot occur in an m-sequence: resync silently.
                        if (sr_next == '0) begin
                            state     <= HUNT;
                            locked_q  <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else if (!match) begin
                            err_q   <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            if (miss_cnt == LOSS_LIM) begin
                                state     <= HUNT;
                                locked_q  <= 1'b0;
                                fill_cnt  <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any increment scheduled above on the same edge.
            if (bus.CLR) begin
                err_cnt <= '0;
            end
        end
    end

    assign bus.LOCKED    = locked_q;
    assign bus.ERR       = err_q;
    assign bus.ERR_COUNT = err_cnt;

endmodule
